// File: rtl/tt_lut_eval.sv
// Truth-table evaluator: serially reloadable LUT with a small in-order result buffer.
// Optional macro TT_EVAL_COUNT_EN adds ones_cnt, a saturating count of popped 1 results.
//
// state  | meaning
// IDLE   | no load active, cfg_valid ignored
// LOAD   | shifting serial table bits into the shadow register
// COMMIT | one cycle: shadow copied to the active table
module tt_lut_eval #(
  parameter int                    N_IN       = 3,
  parameter logic [(1<<N_IN)-1:0]  TT_RESET   = 8'h3D,
  parameter int                    OBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out
`ifdef TT_EVAL_COUNT_EN
  ,
  output logic [15:0]     ones_cnt
`endif
);

  localparam int TW = 1 << N_IN;
  localparam int CW = $clog2(TW) + 1;
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(TW - 1);
  localparam logic [PW:0]   FULL     = (PW + 1)'(OBUF_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]   table_q, table_d;

  logic            mem_q [OBUF_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  logic            ready_en_q;

  logic            push, pop, eval_bit;
  logic [N_IN-1:0] row;

  // Configuration FSM state, bit counter, shadow and active table registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      table_q  <= TT_RESET;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      table_q  <= table_d;
    end
  end

  // Next-state logic: a restart in LOAD discards the shadow, only COMMIT touches the table
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    table_d  = table_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          shadow_d = {shadow_q[TW-2:0], cfg_bit};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = COMMIT;
        end
      end
      COMMIT: begin
        table_d = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_busy = (state_q != IDLE);

  // Table row for in_vec: MSB holds the all-zero row, so the bit index is the complement
  assign row       = ~in_vec;
  assign eval_bit  = table_q[row];

  assign in_ready  = ready_en_q & (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign out       = out_valid & mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Result FIFO; ready_en_q holds in_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) begin
        mem_q[wr_ptr_q] <= eval_bit;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef TT_EVAL_COUNT_EN
  logic [15:0] ones_cnt_q;

  // Saturating count of popped 1 results, cleared whenever a new table commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt_q <= '0;
    end else if (state_q == COMMIT) begin
      ones_cnt_q <= '0;
    end else if (pop && out && (ones_cnt_q != 16'hFFFF)) begin
      ones_cnt_q <= ones_cnt_q + 16'd1;
    end
  end

  assign ones_cnt = ones_cnt_q;
`endif

endmodule

// File: tb/tb_tt_lut_eval.sv
// Directed bench for tt_lut_eval with default parameters (N_IN=3, OBUF_DEPTH=2).
module tb_tt_lut_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_valid, cfg_bit, cfg_busy;
  logic       in_valid, in_ready, out_valid, out_ready, out;
  logic [2:0] in_vec;
`ifdef TT_EVAL_COUNT_EN
  logic [15:0] ones_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tt_lut_eval dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef TT_EVAL_COUNT_EN
    ,
    .ones_cnt  (ones_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp[7] is the expected result for in_vec=0, exp[0] for in_vec=7
  task automatic sweep(input logic [7:0] exp, input string tag);
    out_ready = 1'b1;
    chk({tag, "_idle_ov"}, out_valid, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vec = 3'(i);
      step();
      chk({tag, "_ov"}, out_valid, 1'b1);
      chk({tag, "_out"}, out, exp[7-i]);
    end
    in_valid = 1'b0;
    step();
    chk({tag, "_drain"}, out_valid, 1'b0);
  endtask

  // Starts a load and shifts 8 bits; returns in the COMMIT cycle
  task automatic load(input logic [7:0] bits, input string tag);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk({tag, "_busy_start"}, cfg_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits[7-i];
      step();
      chk({tag, "_busy_load"}, cfg_busy, 1'b1);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_bit = 0;
    in_valid = 0; in_vec = '0; out_ready = 0;
    #1;
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_out", out, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    step(); step();
    rst = 1'b0;
    chk("rst_ready_hold", in_ready, 1'b0);
    step();
    chk("ready_rise", in_ready, 1'b1);

    // Reset table 0x3D
    sweep(8'b0011_1101, "rst_sweep");
`ifdef TT_EVAL_COUNT_EN
    chk("ones_cnt_sweep", ones_cnt, 16'd5);
`endif

    // Reload 0x81; eval of 3'b010 in COMMIT uses old table, next cycle uses new table
    load(8'b1000_0001, "load81");
    in_valid = 1'b1; in_vec = 3'b010; out_ready = 1'b1;
    step();
    chk("commit_busy", cfg_busy, 1'b0);
    chk("commit_ov", out_valid, 1'b1);
    chk("commit_old", out, 1'b1);
`ifdef TT_EVAL_COUNT_EN
    chk("ones_cnt_clr", ones_cnt, 16'd0);
`endif
    step();
    chk("post_commit_new", out, 1'b0);
    in_valid = 1'b0;
    step();
    chk("post_commit_drain", out_valid, 1'b0);
    sweep(8'b1000_0001, "new_sweep");

    // Backpressure with table 0x81: vec0->1, vec1->0, vec7->1
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 3'd0;
    step();
    chk("bp_ov1", out_valid, 1'b1);
    chk("bp_out1", out, 1'b1);
    chk("bp_ready1", in_ready, 1'b1);
    in_vec = 3'd1;
    step();
    chk("bp_full", in_ready, 1'b0);
    chk("bp_out2", out, 1'b1);
    in_vec = 3'd7;
    step();
    chk("bp_full_hold", in_ready, 1'b0);
    chk("bp_stable", out, 1'b1);
    chk("bp_ov3", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    chk("bp_pop_only_out", out, 1'b0);
    chk("bp_pop_only_ready", in_ready, 1'b1);
    step();
    chk("bp_pushpop_out", out, 1'b1);
    chk("bp_pushpop_ov", out_valid, 1'b1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid, 1'b0);

    // Aborted load: 4 zero bits then restart with 0xFF
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      step();
    end
    cfg_valid = 1'b0;
    load(8'hFF, "abort");
    step();
    chk("abort_busy_done", cfg_busy, 1'b0);
    sweep(8'hFF, "abort_sweep");

    // Reset mid-load after 5 bits
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      step();
    end
    cfg_valid = 1'b0;
    chk("midload_busy", cfg_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", cfg_busy, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_ready_rise", in_ready, 1'b1);
    chk("midrst_busy_after", cfg_busy, 1'b0);
    sweep(8'b0011_1101, "midrst_sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_lut_eval.md
TT_LUT_EVAL -- requirements
Module: tt_lut_eval

Interface
REQ-001 Parameter N_IN, default 3: number of logic inputs, legal range 2..6.
REQ-002 Parameter TT_RESET, default 8'h3D: truth table loaded at reset, width 2^N_IN; MSB is the row where all inputs are 0, LSB is the row where all inputs are 1.
REQ-003 Parameter OBUF_DEPTH, default 2: output buffer depth, legal values 2 or 4.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_start  input  1  one-cycle pulse that begins a truth-table load.
REQ-007 cfg_valid  input  1  marks cfg_bit as valid this cycle.
REQ-008 cfg_bit  input  1  serial truth-table bit, MSB (all-inputs-0 row) first.
REQ-009 cfg_busy  output  1  high while a load is in progress.
REQ-010 in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-011 in_vec  input  N_IN  input combination; in_vec[N_IN-1] is in1, the most significant select bit.
REQ-012 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-013 out  output  1  evaluated truth-table bit.

Function
REQ-014 The state machine SHALL have three states: IDLE, LOAD and COMMIT.
REQ-015 In IDLE, cfg_start SHALL move the FSM to LOAD, clear the bit counter and assert cfg_busy on the next cycle.
REQ-016 In LOAD, each cycle with cfg_valid=1 SHALL shift cfg_bit into a shadow register and increment the counter.
REQ-017 The 2^N_IN-th valid bit SHALL move the FSM to COMMIT.
REQ-018 COMMIT SHALL last one cycle: the shadow register is copied to the active table, cfg_busy deasserts, and the FSM returns to IDLE.
REQ-019 cfg_start while in LOAD SHALL restart the load: counter cleared, shadow contents discarded, active table unchanged.
REQ-020 cfg_valid while in IDLE or COMMIT SHALL be ignored.
REQ-021 Evaluation SHALL continue during LOAD using the active table.
REQ-022 An input accepted in the COMMIT cycle SHALL use the old table; inputs accepted from the following cycle onward SHALL use the new table.
REQ-023 in_ready SHALL equal "output buffer not full" (registered occupancy), independent of in_valid.
REQ-024 An accepted input (in_valid & in_ready) SHALL produce table[2^N_IN-1-in_vec], written into the output FIFO at the clock edge where it is accepted.
REQ-025 out_valid SHALL assert in the following cycle, so latency is one cycle.
REQ-026 Results SHALL leave the buffer in acceptance order and are removed on out_valid & out_ready.
REQ-027 While out_valid=1 and out_ready=0, out SHALL hold stable.
REQ-028 With the buffer full, a simultaneous pop SHALL NOT let a push in the same cycle (in_ready is already 0).
REQ-029 With the buffer empty, a push and pop in the same cycle is impossible, because out_valid=0.
REQ-030 In any other state, a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-031 FIFO pointers SHALL wrap modulo OBUF_DEPTH with no data loss.
REQ-032 With out_ready held at 1, the block SHALL sustain one result per cycle.

Reset
REQ-033 Asserting rst SHALL immediately put the FSM in IDLE, clear the counter and FIFO, set the active table to TT_RESET, and force cfg_busy=0, out_valid=0, out=0 and in_ready=0.
REQ-034 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-035 Reset during LOAD SHALL abort the load with no partial commit.

Configuration
REQ-036 Macro TT_EVAL_COUNT_EN, when defined, SHALL add an output port ones_cnt (16-bit) counting popped results with out=1.
REQ-037 ones_cnt SHALL saturate at 16'hFFFF, reset to 0, and clear on COMMIT.
REQ-038 When TT_EVAL_COUNT_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Reset defaults: after reset with N_IN=3, sweep in_vec 0..7 with out_ready=1 -> out sequence 0,0,1,1,1,1,0,1, one result per cycle, out_valid one cycle after each accept.
REQ-040 Reload: load bits 1,0,0,0,0,0,0,1 (function 0x81), then sweep in_vec 0..7 -> out 1,0,0,0,0,0,0,1; cfg_busy high from the cycle after cfg_start through COMMIT.
REQ-041 Eval during load: an eval of in_vec=3'b010 accepted in the COMMIT cycle -> old table bit 1; the same vector accepted the next cycle -> new table bit 0 (new table 0x81).
REQ-042 Backpressure: out_ready=0, push 3 vectors with OBUF_DEPTH=2 -> in_ready drops after 2 accepts; raising out_ready drains results in order with out stable while stalled.
REQ-043 Load abort: cfg_start, 4 bits, then cfg_start again and 8 bits of 0xFF -> all outputs 1.
REQ-044 Reset mid-load: rst after 5 bits -> table reverts to 0x3D and cfg_busy=0.
REQ-045 With TT_EVAL_COUNT_EN: a 0..7 sweep under the reset table -> ones_cnt=5.
